// File: rtl/op_seq_pkg.sv
// Shared types for the frame-synchronous op sequencer: mode decode and FSM states.
package op_seq_pkg;

    typedef enum logic [1:0] {
        MANUAL = 2'b00,
        AUTO   = 2'b01,
        HOLD   = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        S_ORIG,
        S_RUN,
        S_DONE
    } seq_state_t;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_AUTO   = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;

    // Encoding 2'b11 folds into HOLD.
    function automatic mode_t decode_mode(input logic [1:0] m);
        case (m)
            MODE_MANUAL: return MANUAL;
            MODE_AUTO:   return AUTO;
            default:     return HOLD;
        endcase
    endfunction

endpackage

// File: rtl/frame_dwell_counter.sv
// Counts frames spent on the current op in AUTO; expire flags the frame that finishes the dwell.
module frame_dwell_counter #(
    parameter int DWELL_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               inc,
    input  logic [DWELL_W-1:0] dwell,
    output logic               expire
);

    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W:0]   cnt_p1;
    logic [DWELL_W:0]   target;

    // One extra bit so a saturated count plus one still compares correctly.
    always_comb begin
        cnt_p1 = {1'b0, cnt} + (DWELL_W+1)'(1);
        target = (dwell == '0) ? (DWELL_W+1)'(1) : {1'b0, dwell};
        expire = (cnt_p1 >= target);
    end

    always_ff @(posedge clock) begin
        if (reset || clear)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + DWELL_W'(1);
    end

endmodule

// File: rtl/op_sequencer.sv
// Steps the displayed op index only on frame_end, with manual, timed-auto and hold modes.
import op_seq_pkg::*;

module op_sequencer #(
    parameter int N_OPS      = 6,
    parameter int OP_W       = 4,
    parameter int LOOP_START = 1,
    parameter int DWELL_W    = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_end,
    input  logic               keep_coming,
    input  logic [1:0]         mode,
    input  logic               step,
    input  logic               restart,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OP_W-1:0]    current_op,
    output logic               op_changed,
    output logic               wrapped,
    output logic               done
);

    localparam logic [OP_W-1:0] LAST_OP = OP_W'(N_OPS - 1);
    localparam logic [OP_W-1:0] LOOP_OP = OP_W'(LOOP_START);

    seq_state_t      state, state_n;
    mode_t           mode_cur, mode_q;
    logic [OP_W-1:0] op_n;
    logic            chg_n, wrap_n;
    logic            step_pending, restart_pending;
    logic            step_eff, restart_eff;
    logic            expire, advance, cnt_clear, cnt_inc;

    // Requests landing in the frame_end cycle itself are honoured at that boundary.
    always_comb begin
        mode_cur    = decode_mode(mode);
        step_eff    = step_pending || (step && (mode_cur == MANUAL));
        restart_eff = restart_pending || restart;
        advance     = frame_end && !restart_eff &&
                      (((mode_cur == MANUAL) && step_eff) ||
                       ((mode_cur == AUTO) && expire));
        cnt_inc     = frame_end && !restart_eff && (mode_cur == AUTO) && !expire;
        cnt_clear   = (mode_cur != mode_q) ||
                      (frame_end && restart_eff) ||
                      (frame_end && (mode_cur == AUTO) && expire);
    end

    frame_dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .inc    (cnt_inc),
        .dwell  (dwell),
        .expire (expire)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_ORIG;
            current_op <= '0;
            op_changed <= 1'b0;
            wrapped    <= 1'b0;
        end else begin
            state      <= state_n;
            current_op <= op_n;
            op_changed <= chg_n;
            wrapped    <= wrap_n;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            step_pending    <= 1'b0;
            restart_pending <= 1'b0;
            mode_q          <= MANUAL;
        end else begin
            step_pending    <= !frame_end && step_eff;
            restart_pending <= !frame_end && restart_eff;
            mode_q          <= mode_cur;
        end
    end

    always_comb begin
        state_n = state;
        op_n    = current_op;
        chg_n   = 1'b0;
        wrap_n  = 1'b0;
        if (frame_end && restart_eff) begin
            state_n = S_ORIG;
            op_n    = '0;
            chg_n   = (current_op != '0);
        end else if (advance) begin
            if (current_op < LAST_OP) begin
                state_n = S_RUN;
                op_n    = current_op + OP_W'(1);
                chg_n   = 1'b1;
            end else if (keep_coming) begin
                // Pulses even when LOOP_START equals the last op.
                state_n = (LOOP_START == 0) ? S_ORIG : S_RUN;
                op_n    = LOOP_OP;
                chg_n   = 1'b1;
                wrap_n  = 1'b1;
            end else begin
                state_n = S_DONE;
            end
        end
    end

    always_comb begin
        done = (state == S_DONE);
    end

endmodule

// File: tb/tb_op_sequencer.sv
// Frame-level vector table for op_sequencer with a scoreboard of post-frame_end expectations.
module tb_op_sequencer;

    logic       clock = 1'b0;
    logic       reset, frame_end, keep_coming, step, restart;
    logic [1:0] mode;
    logic [7:0] dwell;
    logic [3:0] current_op;
    logic       op_changed, wrapped, done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] mode;
        logic       step;
        logic       restart;
        logic       keep;
        logic [7:0] dwell;
        logic [3:0] op;
        logic       chg;
        logic       wrap;
        logic       dn;
    } vec_t;

    typedef struct {
        logic [3:0] op;
        logic       chg;
        logic       wrap;
        logic       dn;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    op_sequencer #(.N_OPS(6), .OP_W(4), .LOOP_START(1), .DWELL_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_end   (frame_end),
        .keep_coming (keep_coming),
        .mode        (mode),
        .step        (step),
        .restart     (restart),
        .dwell       (dwell),
        .current_op  (current_op),
        .op_changed  (op_changed),
        .wrapped     (wrapped),
        .done        (done)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic [1:0] m, input logic s, input logic r,
                                input logic k, input logic [7:0] d, input logic [3:0] op,
                                input logic c, input logic w, input logic dn);
        vec_t v;
        v.mode = m; v.step = s; v.restart = r; v.keep = k; v.dwell = d;
        v.op = op; v.chg = c; v.wrap = w; v.dn = dn;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic compare_sb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, " sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        check({tag, " op"}, int'(current_op), int'(e.op));
        check({tag, " op_changed"}, int'(op_changed), int'(e.chg));
        check({tag, " wrapped"}, int'(wrapped), int'(e.wrap));
        check({tag, " done"}, int'(done), int'(e.dn));
    endtask

    // One frame: settle controls, optional request pulses, then the frame_end boundary.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        mode = v.mode; keep_coming = v.keep; dwell = v.dwell;
        tick();
        step = v.step; restart = v.restart;
        tick();
        step = 1'b0; restart = 1'b0;
        tick();
        frame_end = 1'b1;
        e.op = v.op; e.chg = v.chg; e.wrap = v.wrap; e.dn = v.dn;
        sb.push_back(e);
        tick();
        frame_end = 1'b0;
        compare_sb($sformatf("vec%0d", idx));
        tick();
        check($sformatf("vec%0d chg_pulse", idx), int'(op_changed), 0);
        check($sformatf("vec%0d wrap_pulse", idx), int'(wrapped), 0);
    endtask

    initial begin
        reset = 1'b1; frame_end = 1'b0; keep_coming = 1'b0; step = 1'b0;
        restart = 1'b0; mode = 2'b00; dwell = 8'd0;

        // MANUAL single step, then two idle frames
        vecs.push_back(mk(2'b00, 1, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 1, 0, 0, 0));
        // restart back to 0 from op 1
        vecs.push_back(mk(2'b00, 0, 1, 0, 0, 0, 1, 0, 0));
        // AUTO dwell=3, keep=1: 0,1,2,3,4,5 then wrap to 1
        for (int k = 1; k <= 18; k++) begin
            int a;
            a = k / 3;
            vecs.push_back(mk(2'b01, 0, 0, 1, 8'd3, (a <= 5) ? 4'(a) : 4'd1,
                              (k % 3) == 0, k == 18, 0));
        end
        // AUTO dwell=0 (=1), keep=0: 2..5, then stuck done, then wrap on keep
        for (int k = 2; k <= 5; k++)
            vecs.push_back(mk(2'b01, 0, 0, 0, 8'd0, 4'(k), 1, 0, 0));
        vecs.push_back(mk(2'b01, 0, 0, 0, 8'd0, 5, 0, 0, 1));
        vecs.push_back(mk(2'b01, 0, 0, 0, 8'd0, 5, 0, 0, 1));
        vecs.push_back(mk(2'b01, 0, 0, 1, 8'd0, 1, 1, 1, 0));
        // MANUAL to 3, step+restart together, then consumed step, restart at 0
        vecs.push_back(mk(2'b00, 1, 0, 1, 0, 2, 1, 0, 0));
        vecs.push_back(mk(2'b00, 1, 0, 1, 0, 3, 1, 0, 0));
        vecs.push_back(mk(2'b00, 1, 1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(2'b00, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b00, 0, 1, 1, 0, 0, 0, 0, 0));
        // HOLD at 2 ignores steps, mode 11 too; AUTO dwell=2 advances on 2nd frame
        vecs.push_back(mk(2'b00, 1, 0, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(2'b00, 1, 0, 1, 0, 2, 1, 0, 0));
        for (int k = 0; k < 10; k++)
            vecs.push_back(mk(2'b10, 1, 0, 1, 8'd2, 2, 0, 0, 0));
        vecs.push_back(mk(2'b11, 1, 0, 1, 8'd2, 2, 0, 0, 0));
        vecs.push_back(mk(2'b01, 0, 0, 1, 8'd2, 2, 0, 0, 0));
        vecs.push_back(mk(2'b01, 0, 0, 1, 8'd2, 3, 1, 0, 0));
        vecs.push_back(mk(2'b00, 1, 0, 1, 0, 4, 1, 0, 0));

        tick(); tick();
        reset = 1'b0;
        tick();
        check("reset op", int'(current_op), 0);
        check("reset op_changed", int'(op_changed), 0);
        check("reset wrapped", int'(wrapped), 0);
        check("reset done", int'(done), 0);

        foreach (vecs[i]) apply(vecs[i], i);

        // Reset coincident with frame_end while a step is pending at op 4
        mode = 2'b00;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        reset = 1'b1; frame_end = 1'b1;
        tick();
        reset = 1'b0; frame_end = 1'b0;
        check("rst_fe op", int'(current_op), 0);
        check("rst_fe op_changed", int'(op_changed), 0);
        check("rst_fe wrapped", int'(wrapped), 0);
        check("rst_fe done", int'(done), 0);
        // Pending step must have been discarded by reset
        tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check("rst_lost_step op", int'(current_op), 0);
        check("rst_lost_step op_changed", int'(op_changed), 0);

        // Step arriving in the frame_end cycle counts for that boundary
        tick();
        step = 1'b1; frame_end = 1'b1;
        tick();
        step = 1'b0; frame_end = 1'b0;
        check("same_cycle_step op", int'(current_op), 1);
        check("same_cycle_step op_changed", int'(op_changed), 1);

        check("sb drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
